// File: rtl/mon_pkg.sv
// Shared types and helpers for the DFF pin monitor: the record layout and the FIFO depth check.
package mon_pkg;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned CNT_W_DEF = 16;

    // Record layout at the default counter width; mon_dff rebuilds it at its own CNT_W.
    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [CNT_W_DEF-1:0] stamp;
        logic                 din;
        logic                 dout;
        logic                 mismatch;
    } mon_rec_t;

    localparam int unsigned REC_W = $bits(mon_rec_t);

    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int unsigned rec_width(input int unsigned cnt_w);
        return ID_W + cnt_w + 3;
    endfunction

    localparam bit DEPTH_DEF_OK = is_pow2(16);

endpackage

// File: rtl/mon_fifo.sv
// Synchronous record FIFO; extra pointer MSB separates full from empty, push+pop allowed when full.
module mon_fifo
    import mon_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type         rec_t = mon_rec_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  rec_t                   i_din,
    input  logic                   i_pop,
    output rec_t                   o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    rec_t          r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_rd = i_pop && !o_empty;
    // When full, a same-edge pop frees the head slot, which is exactly where the write lands.
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_level;

endmodule

// File: rtl/mon_dff.sv
// Passive monitor for a one-cycle DFF: predicts dout from the previous din, counts mismatches,
// and logs every checked cycle into a record FIFO drained over valid/ready.
module mon_dff
    import mon_pkg::*;
#(
    parameter int unsigned ID    = 1,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_din,
    input  logic                   i_dout,
    input  logic                   i_en,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [CNT_W+10:0]      o_rd_data,
    output logic                   o_mismatch,
    output logic [CNT_W-1:0]       o_err_cnt,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_level
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] stamp;
        logic             din;
        logic             dout;
        logic             mismatch;
    } rec_t;

    localparam int unsigned RecW = rec_width(CNT_W);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("mon_dff: DEPTH must be a power of two and at least 2");
    end
    if ($bits(rec_t) != RecW) begin : g_bad_rec
        $error("mon_dff: record width does not match rec_width()");
    end

    logic             r_exp;
    logic             r_primed;
    logic             r_mismatch;
    logic             r_overflow;
    logic [CNT_W-1:0] r_stamp;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_check;
    logic             w_miss;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    rec_t             w_rec;
    rec_t             w_head;

    // A check needs a prediction captured on the previous enabled edge.
    assign w_check = i_en && r_primed;
    assign w_miss  = (i_dout != r_exp);
    assign w_pop   = o_rd_valid && i_rd_ready;

    always_comb begin
        w_rec          = '0;
        w_rec.id       = ID_W'(ID);
        w_rec.stamp    = r_stamp;
        w_rec.din      = i_din;
        w_rec.dout     = i_dout;
        w_rec.mismatch = w_miss;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp      <= 1'b0;
            r_primed   <= 1'b0;
            r_mismatch <= 1'b0;
            r_overflow <= 1'b0;
            r_stamp    <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_stamp    <= r_stamp + CNT_W'(1);
            r_primed   <= i_en;
            r_mismatch <= w_check && w_miss;
            if (i_en) begin
                r_exp <= i_din;
            end
            if (w_check && w_miss && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_check && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    mon_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_check),
        .i_din   (w_rec),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    assign o_rd_valid = !w_empty;
    assign o_rd_data  = w_head;
    assign o_mismatch = r_mismatch;
    assign o_err_cnt  = r_err_cnt;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_mon_dff.sv
// Bench for mon_dff: directed scenarios then random traffic, all checked against a queue-based model.
module tb_mon_dff;

    localparam int unsigned ID    = 90;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned RW    = CNT_W + 11;
    localparam int          MAXERR = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   din;
    logic                   dout;
    logic                   en;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [RW-1:0]          rd_data;
    logic                   mismatch;
    logic [CNT_W-1:0]       err_cnt;
    logic                   overflow;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    mon_dff #(
        .ID    (ID),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_din      (din),
        .i_dout     (dout),
        .i_en       (en),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
        .o_mismatch (mismatch),
        .o_err_cnt  (err_cnt),
        .o_overflow (overflow),
        .o_level    (level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [RW-1:0] m_q [$];
    int            m_stamp  = 0;
    int            m_err    = 0;
    bit            m_exp    = 1'b0;
    bit            m_primed = 1'b0;
    bit            m_mis    = 1'b0;
    bit            m_ovf    = 1'b0;
    bit            last_din = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance model with the same inputs, compare at next negedge.
    // bad=1 makes the emulated DFF output the inverse of what it should.
    task automatic cyc(input bit rst_v, input bit en_v, input bit din_v, input bit bad_v,
                       input bit rdy_v);
        bit            chk;
        bit            m;
        bit            dout_v;
        logic [RW-1:0] rec;
        dout_v   = bad_v ? ~last_din : last_din;
        rst      = rst_v;
        en       = en_v;
        din      = din_v;
        dout     = dout_v;
        rd_ready = rdy_v;

        if (rst_v) begin
            m_q.delete();
            m_stamp  = 0;
            m_err    = 0;
            m_exp    = 1'b0;
            m_primed = 1'b0;
            m_mis    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            chk = en_v && m_primed;
            m   = (dout_v != m_exp);
            if (rdy_v && m_q.size() > 0) void'(m_q.pop_front());
            m_mis = chk && m;
            if (chk) begin
                if (m && m_err < MAXERR) m_err++;
                rec = {8'(ID), CNT_W'(m_stamp), din_v, dout_v, m};
                if (m_q.size() < DEPTH) m_q.push_back(rec);
                else m_ovf = 1'b1;
            end
            if (en_v) m_exp = din_v;
            m_primed = en_v;
            m_stamp  = (m_stamp + 1) % (1 << CNT_W);
        end
        last_din = din_v;

        @(posedge clk);
        @(negedge clk);
        check_eq("rd_valid", rd_valid, m_q.size() > 0);
        check_eq("level", level, m_q.size());
        check_eq("mismatch", mismatch, m_mis);
        check_eq("err_cnt", err_cnt, m_err);
        check_eq("overflow", overflow, m_ovf);
        if (m_q.size() > 0) check_eq("rd_data", rd_data, m_q[0]);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; dout = 1'b0; rd_ready = 1'b0;

        // Reset state, then din 1,0,1,1 with a correct DUT: three records
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("t1_level", level, 3);
        check_eq("t1_first_din_dout", rd_data[2:1], 2'b01);
        repeat (4) cyc(0, 0, 0, 0, 1);

        // dout stuck at 0 while din=1: five checked mismatches
        repeat (6) cyc(0, 1, 1, 1, 1);
        check_eq("t2_err", err_cnt, 5);

        // Fill past DEPTH without reading, then drain
        cyc(1, 0, 0, 0, 0);
        repeat (7) cyc(0, 1, 1'($urandom), 0, 0);
        check_eq("t3_level", level, DEPTH);
        check_eq("t3_ovf", overflow, 1);
        repeat (5) cyc(0, 0, 0, 0, 1);
        check_eq("t3_drained", level, 0);

        // Full FIFO with simultaneous pop during a check: no drop
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 1'($urandom), 0, 0);
        cyc(0, 1, 1'($urandom), 0, 1);
        check_eq("t4_level", level, DEPTH);
        check_eq("t4_ovf", overflow, 0);
        repeat (5) cyc(0, 0, 0, 0, 1);

        // Error counter saturation and stamp wrap
        cyc(1, 0, 0, 0, 0);
        repeat (21) cyc(0, 1, 1'($urandom), 1, 1'($urandom));
        check_eq("t5_err_sat", err_cnt, MAXERR);

        // Mid-stream reset with queued records and errors
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check_eq("t6_pre_level", level, 3);
        check_eq("t6_pre_err", err_cnt, 2);
        cyc(1, 1, 1, 1, 0);
        check_eq("t6_rst_valid", rd_valid, 0);
        check_eq("t6_rst_err", err_cnt, 0);
        cyc(0, 1, 1, 1, 0);
        check_eq("t6_no_check", mismatch, 0);
        check_eq("t6_no_rec", level, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(7) != 0), 1'($urandom),
                ($urandom_range(5) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
